// File: rtl/bit_pix_bram_writer.sv
// bit_pix_bram_writer
//
// Write-side sequencer for the bit-pixel BRAM that feeds the block matcher.
// The block takes in a 16-bit Avalon-ST stream of packed bit-pixels. Each
// packet is one frame, and its first word carries SOP. The block drives the
// BRAM write port with a word address, a third index and a write strobe.
// Frames alternate between two buffers (ping-pong). A buffer that the block
// matcher is still reading is held off, but only before a frame starts.
//
// Frame layout: left third (0), center third (1), right third (2), one after
// another. The thirds hold THIRD_END, CENTER_END and THIRD_END words. In
// buffer 1, each word address is offset by the word count of its own third.
//
// Ports
//   clk, reset_n          single clock, asynchronous active-low reset
//   asi_valid/asi_data/asi_startofpacket/asi_ready
//                         Avalon-ST sink (LSB of asi_data = leftmost pixel)
//   wr_address/wr_third/wr_writedata/wr_write
//                         registered BRAM write port, one cycle after acceptance
//   bm_idle, bm_working_buf
//                         block-matcher status used to hold off a busy buffer
//   buf_index             buffer currently being filled
//   image_number          count of completed frames
//   frame_done            one-cycle pulse on the last write of a frame
//   sync_err              one-cycle pulse when SOP restarts a frame mid-stream
//
// Optional feature macro: BPW_SOP_RESYNC_EN
//   defined   - SOP seen while writing restarts the frame at (third 0, word 0)
//               of the same buffer and pulses sync_err
//   undefined - SOP while writing is ignored; sync_err is tied low

module bit_pix_bram_writer #(
  parameter int THIRD_WIDTH  = 240,
  parameter int CENTER_WIDTH = 304,
  parameter int THIRD_HEIGHT = 480,
  parameter int WORD_BITS    = 16
) (
  input  logic        clk,
  input  logic        reset_n,

  input  logic        asi_valid,
  input  logic [15:0] asi_data,
  input  logic        asi_startofpacket,
  output logic        asi_ready,

  output logic [15:0] wr_address,
  output logic [1:0]  wr_third,
  output logic [15:0] wr_writedata,
  output logic        wr_write,

  input  logic        bm_idle,
  input  logic        bm_working_buf,

  output logic        buf_index,
  output logic [31:0] image_number,
  output logic        frame_done,
  output logic        sync_err
);

  localparam logic [15:0] THIRD_END  = 16'(THIRD_WIDTH  * THIRD_HEIGHT / WORD_BITS);
  localparam logic [15:0] CENTER_END = 16'(CENTER_WIDTH * THIRD_HEIGHT / WORD_BITS);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_WRITE = 1'b1;

  // State registers
  logic [0:0]  state_q,        state_d;
  logic [15:0] word_addr_q,    word_addr_d;
  logic [1:0]  third_q,        third_d;
  logic        buf_index_q,    buf_index_d;
  logic [31:0] image_number_q, image_number_d;

  // Registered write-port outputs
  logic [15:0] wr_address_q,   wr_address_d;
  logic [1:0]  wr_third_q,     wr_third_d;
  logic [15:0] wr_writedata_q, wr_writedata_d;
  logic        wr_write_q,     wr_write_d;
  logic        frame_done_q,   frame_done_d;
  logic        sync_err_q,     sync_err_d;

  // Combinational helpers
  logic        buf_busy;
  logic        accept;
  logic        do_write;
  logic [1:0]  tgt_third;
  logic [15:0] tgt_word;
  logic [15:0] tgt_end;

  // The busy check only gates IDLE. Once a frame is in progress it runs to
  // the end without stalling, so the block matcher must finish first.
  always_comb begin
    buf_busy  = !bm_idle && (bm_working_buf == buf_index_q);
    asi_ready = (state_q == ST_WRITE) || !buf_busy;
    accept    = asi_valid && asi_ready;
  end

  always_comb begin
    state_d        = state_q;
    word_addr_d    = word_addr_q;
    third_d        = third_q;
    buf_index_d    = buf_index_q;
    image_number_d = image_number_q;

    wr_address_d   = wr_address_q;
    wr_third_d     = wr_third_q;
    wr_writedata_d = wr_writedata_q;
    wr_write_d     = 1'b0;
    frame_done_d   = 1'b0;
    sync_err_d     = 1'b0;

    do_write  = 1'b0;
    tgt_third = third_q;
    tgt_word  = word_addr_q;

    // Decide whether this beat is written, and where.
    if (accept) begin
      if (state_q == ST_IDLE) begin
        // Non-SOP beats in IDLE are consumed and discarded.
        if (asi_startofpacket) begin
          do_write  = 1'b1;
          tgt_third = 2'd0;
          tgt_word  = 16'd0;
          state_d   = ST_WRITE;
        end
      end else begin
        do_write = 1'b1;
`ifdef BPW_SOP_RESYNC_EN
        // Restart inside the same buffer. The partial frame is overwritten,
        // so there is no toggle and no count.
        if (asi_startofpacket) begin
          tgt_third  = 2'd0;
          tgt_word   = 16'd0;
          sync_err_d = 1'b1;
        end
`endif
      end
    end

    tgt_end = (tgt_third == 2'd1) ? CENTER_END : THIRD_END;

    if (do_write) begin
      wr_write_d     = 1'b1;
      wr_third_d     = tgt_third;
      wr_writedata_d = asi_data;
      // Buffer 1 starts right after buffer 0 within each third.
      wr_address_d   = buf_index_q ? (tgt_end + tgt_word) : tgt_word;

      // Advance from the word that was just written.
      if (tgt_word == tgt_end - 16'd1) begin
        word_addr_d = 16'd0;
        if (tgt_third == 2'd2) begin
          third_d        = 2'd0;
          frame_done_d   = 1'b1;
          buf_index_d    = !buf_index_q;
          image_number_d = image_number_q + 32'd1;
          state_d        = ST_IDLE;
        end else begin
          third_d = tgt_third + 2'd1;
        end
      end else begin
        word_addr_d = tgt_word + 16'd1;
        third_d     = tgt_third;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      word_addr_q    <= 16'd0;
      third_q        <= 2'd0;
      buf_index_q    <= 1'b0;
      image_number_q <= 32'd0;
      wr_address_q   <= 16'd0;
      wr_third_q     <= 2'd0;
      wr_writedata_q <= 16'd0;
      wr_write_q     <= 1'b0;
      frame_done_q   <= 1'b0;
      sync_err_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      word_addr_q    <= word_addr_d;
      third_q        <= third_d;
      buf_index_q    <= buf_index_d;
      image_number_q <= image_number_d;
      wr_address_q   <= wr_address_d;
      wr_third_q     <= wr_third_d;
      wr_writedata_q <= wr_writedata_d;
      wr_write_q     <= wr_write_d;
      frame_done_q   <= frame_done_d;
      sync_err_q     <= sync_err_d;
    end
  end

  assign wr_address   = wr_address_q;
  assign wr_third     = wr_third_q;
  assign wr_writedata = wr_writedata_q;
  assign wr_write     = wr_write_q;
  assign buf_index    = buf_index_q;
  assign image_number = image_number_q;
  assign frame_done   = frame_done_q;
`ifdef BPW_SOP_RESYNC_EN
  assign sync_err     = sync_err_q;
`else
  assign sync_err     = 1'b0;
`endif

endmodule

// File: tb/tb_bit_pix_bram_writer.sv
module tb_bit_pix_bram_writer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        asi_valid = 1'b0;
  logic [15:0] asi_data = 16'd0;
  logic        asi_startofpacket = 1'b0;
  logic        asi_ready;
  logic [15:0] wr_address;
  logic [1:0]  wr_third;
  logic [15:0] wr_writedata;
  logic        wr_write;
  logic        bm_idle = 1'b1;
  logic        bm_working_buf = 1'b0;
  logic        buf_index;
  logic [31:0] image_number;
  logic        frame_done;
  logic        sync_err;

  bit_pix_bram_writer dut (
    .clk(clk), .reset_n(reset_n),
    .asi_valid(asi_valid), .asi_data(asi_data),
    .asi_startofpacket(asi_startofpacket), .asi_ready(asi_ready),
    .wr_address(wr_address), .wr_third(wr_third),
    .wr_writedata(wr_writedata), .wr_write(wr_write),
    .bm_idle(bm_idle), .bm_working_buf(bm_working_buf),
    .buf_index(buf_index), .image_number(image_number),
    .frame_done(frame_done), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] addr;
    logic [1:0]  third;
    logic [15:0] data;
    logic        fd;
    logic        se;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   wcount = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, req);
    end
  endtask

  // Monitor: pop one expectation per observed write
  always @(negedge clk) begin
    if (reset_n) begin
      if (wr_write) begin
        wcount++;
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_write: addr=%0d third=%0d", wr_address, wr_third);
        end else begin
          exp_t e;
          exp_t a;
          e = sb.pop_front();
          a = '{wr_address, wr_third, wr_writedata, frame_done, sync_err};
          check("write", 64'(a), 64'(e));
        end
      end else if (frame_done || sync_err) begin
        total++; bad++;
        $display("FAIL stray_pulse: frame_done=%0b sync_err=%0b", frame_done, sync_err);
      end
    end
  end

  function automatic logic [15:0] dat(input int f, input int k);
    return 16'((k * 7 + f * 4099) ^ (k >> 3));
  endfunction

  // Present one beat and hold it until it is accepted.
  task automatic send(input logic [15:0] d, input logic sop, input bit expw, input exp_t e);
    int n;
    asi_valid = 1'b1; asi_data = d; asi_startofpacket = sop;
    n = 0;
    while (!asi_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 200) begin
      total++; bad++;
      $display("FAIL ready_timeout: asi_ready=%0b want=1", asi_ready);
    end
    if (expw) sb.push_back(e);
    @(posedge clk); #1;
    asi_valid = 1'b0; asi_startofpacket = 1'b0;
  endtask

  // Stream frame words k in [start_k, stop_k). The frame layout is walked
  // third by third, so each expected address comes from the layout.
  task automatic run_frame(input int f, input bit bsel, input int start_k,
                           input int stop_k, input bit gaps);
    int k;
    k = 0;
    for (int t = 0; t < 3; t++) begin
      int len;
      len = (t == 1) ? 9120 : 7200;
      for (int w = 0; w < len; w++) begin
        if (k >= start_k && k < stop_k) begin
          exp_t e;
          e.addr  = 16'(bsel ? len + w : w);
          e.third = 2'(t);
          e.data  = dat(f, k);
          e.fd    = (t == 2 && w == len - 1);
          e.se    = 1'b0;
          if (gaps && $urandom_range(15) == 0) begin
            int g;
            g = $urandom_range(5);
            repeat (g) begin @(posedge clk); #1; end
          end
          send(dat(f, k), k == 0, 1'b1, e);
        end
        k++;
      end
    end
  endtask

  task automatic drain;
    repeat (3) begin @(posedge clk); #1; end
  endtask

  initial begin
    exp_t e;
    exp_t none;
    none = '0;

    // Reset state
    #12;
    check("rst_wr_write", 64'(wr_write), 64'd0);
    check("rst_wr_address", 64'(wr_address), 64'd0);
    check("rst_wr_writedata", 64'(wr_writedata), 64'd0);
    check("rst_buf_index", 64'(buf_index), 64'd0);
    check("rst_image_number", 64'(image_number), 64'd0);
    check("rst_pulses", 64'({frame_done, sync_err}), 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("idle_ready", 64'(asi_ready), 64'd1);

    // Non-SOP beats in IDLE are consumed and dropped
    for (int i = 0; i < 3; i++) send(16'hA000 + 16'(i), 1'b0, 1'b0, none);
    drain();
    check("drop_no_writes", 64'(wcount), 64'd0);

    // A busy buffer holds off SOP; releasing it accepts the beat at once
    bm_idle = 1'b0; bm_working_buf = 1'b0;
    asi_valid = 1'b1; asi_data = dat(1, 0); asi_startofpacket = 1'b1;
    #1;
    check("busy_ready_low", 64'(asi_ready), 64'd0);
    repeat (4) begin @(posedge clk); #1; end
    check("busy_no_writes", 64'(wcount), 64'd0);
    check("busy_ready_still_low", 64'(asi_ready), 64'd0);
    bm_idle = 1'b1;
    #1;
    check("release_ready_high", 64'(asi_ready), 64'd1);
    e = '{16'd0, 2'd0, dat(1, 0), 1'b0, 1'b0};
    sb.push_back(e);
    @(posedge clk); #1;
    asi_valid = 1'b0; asi_startofpacket = 1'b0;
    check("first_write_next_cycle", 64'({wr_write, wr_address, wr_third}), {46'd0, 1'b1, 16'd0, 2'd0});

    // Frame 1, contiguous, buffer 0
    run_frame(1, 1'b0, 1, 23520, 1'b0);
    check("f1_buf_index", 64'(buf_index), 64'd1);
    check("f1_image_number", 64'(image_number), 64'd1);
    drain();
    check("f1_write_count", 64'(wcount), 64'd23520);

    // Frame 2, random gaps, buffer 1 (matcher idle so not busy)
    run_frame(2, 1'b1, 0, 23520, 1'b1);
    check("f2_buf_index", 64'(buf_index), 64'd0);
    check("f2_image_number", 64'(image_number), 64'd2);
    drain();
    check("f2_write_count", 64'(wcount), 64'd47040);
    check("f2_scoreboard_empty", 64'(sb.size()), 64'd0);

    // SOP arriving at third 1, word 100 of frame 3
    run_frame(3, 1'b0, 0, 7300, 1'b0);
`ifdef BPW_SOP_RESYNC_EN
    e = '{16'd0, 2'd0, 16'hBEEF, 1'b0, 1'b1};
    send(16'hBEEF, 1'b1, 1'b1, e);
    e = '{16'd1, 2'd0, 16'hBEF0, 1'b0, 1'b0};
    send(16'hBEF0, 1'b0, 1'b1, e);
`else
    e = '{16'd100, 2'd1, 16'hBEEF, 1'b0, 1'b0};
    send(16'hBEEF, 1'b1, 1'b1, e);
    e = '{16'd101, 2'd1, 16'hBEF0, 1'b0, 1'b0};
    send(16'hBEF0, 1'b0, 1'b1, e);
`endif
    drain();
    check("resync_image_number", 64'(image_number), 64'd2);
    check("resync_buf_index", 64'(buf_index), 64'd0);

    // Reset mid-frame clears everything right away
    asi_valid = 1'b1; asi_data = 16'h1234; asi_startofpacket = 1'b0;
    #1;
    reset_n = 1'b0;
    #1;
    asi_valid = 1'b0;
    check("midrst_write", 64'(wr_write), 64'd0);
    check("midrst_addr", 64'(wr_address), 64'd0);
    check("midrst_image", 64'(image_number), 64'd0);
    check("midrst_buf", 64'(buf_index), 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    drain();
    check("final_scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: sim time exceeded");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bit_pix_bram_writer.md
# bit_pix_bram_writer

Write-side sequencer for the bit-pixel BRAM feeding the block matcher. Accepts a 16-bit Avalon-ST stream of packed bit-pixels, one frame per packet, and drives the BRAM write port: word address, third index and write strobe, ping-ponging between two buffers. It sits between the census/bit-pixel front end and `bit_pix_bram_mod`, and holds off a buffer the block-match FSM is still reading.

## Interface
- `THIRD_WIDTH`, 240, pixel width of left/right thirds
- `CENTER_WIDTH`, 304, pixel width of center third
- `THIRD_HEIGHT`, 480, rows per third
- `WORD_BITS`, 16, pixels per write word
- `clk`  in  1  single clock
- `reset_n`  in  1  asynchronous, active-low reset
- `asi_valid`  in  1  stream beat valid
- `asi_data`  in  16  packed bit-pixels, LSB = leftmost pixel
- `asi_startofpacket`  in  1  first word of a frame
- `asi_ready`  out  1  beat accepted when `asi_valid & asi_ready`
- `wr_address`  out  16  BRAM word address, buffer offset included
- `wr_third`  out  2  0 = left, 1 = center, 2 = right
- `wr_writedata`  out  16  registered `asi_data`
- `wr_write`  out  1  write strobe
- `bm_idle`  in  1  block matcher idle
- `bm_working_buf`  in  1  buffer the block matcher is reading
- `buf_index`  out  1  buffer currently being filled
- `image_number`  out  32  completed frame count
- `frame_done`  out  1  one-cycle pulse on the last write of a frame
- `sync_err`  out  1  one-cycle pulse on a mid-frame resync

## Operation
- Derived: `THIRD_END` = THIRD_WIDTH*THIRD_HEIGHT/WORD_BITS (7200); `CENTER_END` = CENTER_WIDTH*THIRD_HEIGHT/WORD_BITS (9120); `end_i` = CENTER_END when `third`==1, else THIRD_END.
- Output address: `wr_address` = buf ? end_i + word_addr : word_addr. Width is 16 bits; the maximum is 9120+9119 = 18239, which fits.
- `buf_busy` = `!bm_idle & (bm_working_buf == buf_index)`.
- FSM IDLE:
  - `asi_ready` = `!buf_busy`.
  - Accepted beats without SOP are dropped.
  - An accepted SOP beat writes to (third 0, word 0) and moves to WRITE.
- FSM WRITE:
  - `asi_ready` = 1; every accepted beat is written.
  - word_addr increments. At `end_i-1` it wraps to 0 and third increments.
  - On the last word of third 2: `frame_done` pulses, `buf_index` toggles, `image_number` increments by 1, third resets to 0, and the FSM goes to IDLE.
- `buf_busy` is sampled only in IDLE. Once a frame has started, it is not stalled.
- Reset values: FSM = IDLE, word_addr = 0, third = 0, `buf_index` = 0, `image_number` = 0, all strobes/pulses = 0, `wr_address` = 0, `wr_writedata` = 0.
- `asi_ready` is combinational from FSM state, `bm_idle` and `bm_working_buf`.

## Timing
- Beat accepted in cycle N → `wr_write`, `wr_address`, `wr_third`, `wr_writedata` valid in cycle N+1. Latency is 1 and throughput is 1 word/cycle.
- `frame_done` is coincident with the final `wr_write`. `buf_index` and `image_number` update in the same edge, so both are new in cycle N+1.
- Gaps in `asi_valid`: `wr_write` = 0 and the counters hold.
- `buf_busy` deasserting in cycle N: `asi_ready` goes high in cycle N.
- Reset asserted mid-frame: all state clears immediately. The partial buffer is abandoned; `image_number` and `buf_index` return to 0.

## Configuration
- Macro: `BPW_SOP_RESYNC_EN`.
- Defined:
  - An accepted SOP beat in WRITE pulses `sync_err`.
  - That beat is written to (third 0, word 0) of the same buffer.
  - No toggle and no `image_number` increment.
- Undefined:
  - SOP in WRITE is ignored and the beat is written sequentially.
  - `sync_err` is tied to 0.

## Test plan
- Reset, then stream 23520 contiguous words with SOP on the first → addresses 0..7199 (third 0), 0..9119 (third 1), 0..7199 (third 2). `frame_done` on the 23520th write; `buf_index`=1, `image_number`=1.
- Second frame with `buf_index`=1 → third 0 addresses 7200..14399, third 1 addresses 9120..18239. After it: `buf_index`=0, `image_number`=2.
- `bm_idle`=0, `bm_working_buf`=0 after reset, SOP presented → `asi_ready`=0 and no writes. Drop `bm_idle` to 1 → first write appears at address 0, third 0, the next cycle.
- Random `asi_valid` gaps of 0–5 cycles over one frame → write count 23520, no address skips or repeats, `wr_writedata` matches input order.
- Three non-SOP beats, then SOP in IDLE → the first three beats are accepted and dropped; the first write is the SOP word at address 0.
- `BPW_SOP_RESYNC_EN` defined, SOP at third 1 word 100 → `sync_err` pulse; that word is written at third 0 address 0; `image_number` is unchanged. Undefined → that word is written at third 1 address 100 and `sync_err` stays 0.
